// File: rtl/cnu_msg_gen.sv
// Check-node output stage: buffers compressed min-sum records and expands each one
// into D offset-corrected sign-magnitude check-to-variable messages, one edge per beat.
module cnu_msg_gen #(
  parameter int data_w = 9,
  parameter int D      = 7,
  parameter int OFFSET = 1,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_min,
  input  logic [data_w-1:0] in_min2,
  input  logic [D-1:0]      in_min_idx,
  input  logic [D-1:0]      in_signs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_msg,
  output logic [2:0]        out_edge,
  output logic              out_last
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [2:0]        LAST_EDGE = 3'(D - 1);
  localparam logic [data_w-1:0] OFF_C     = data_w'(OFFSET);

  // Record storage; contents need no reset, only the pointers do.
  logic [data_w-1:0] min_mem   [DEPTH];
  logic [data_w-1:0] min2_mem  [DEPTH];
  logic [D-1:0]      idx_mem   [DEPTH];
  logic [D-1:0]      signs_mem [DEPTH];
  logic              par_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [2:0]    ecnt_q,   ecnt_d;

  logic push, beat, pop;

  logic [data_w-1:0] head_min, head_min2;
  logic [D-1:0]      head_idx, head_signs;
  logic              head_par;

  logic [data_w-1:0] edge_mag  [D];
  logic              edge_sign [D];
  logic [data_w-1:0] sel_mag;
  logic              sel_sign;

  assign in_ready  = !rst && (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && (ecnt_q == LAST_EDGE);

  always_ff @(posedge clk) begin
    if (push) begin
      min_mem[wr_ptr_q]   <= in_min;
      min2_mem[wr_ptr_q]  <= in_min2;
      idx_mem[wr_ptr_q]   <= in_min_idx;
      signs_mem[wr_ptr_q] <= in_signs;
      par_mem[wr_ptr_q]   <= ^in_signs;
    end
  end

  assign head_min   = min_mem[rd_ptr_q];
  assign head_min2  = min2_mem[rd_ptr_q];
  assign head_idx   = idx_mem[rd_ptr_q];
  assign head_signs = signs_mem[rd_ptr_q];
  assign head_par   = par_mem[rd_ptr_q];

  // Every edge's message is formed in parallel; the edge counter just selects one.
  // Magnitude saturates at zero so a small raw value never wraps.
  for (genvar gi = 0; gi < D; gi++) begin : g_edge
    logic [data_w-1:0] raw;
    assign raw           = head_idx[gi] ? head_min2 : head_min;
    assign edge_mag[gi]  = (raw > OFF_C) ? (raw - OFF_C) : '0;
    assign edge_sign[gi] = head_par ^ head_signs[gi];
  end

  always_comb begin
    sel_mag  = '0;
    sel_sign = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (ecnt_q == 3'(k)) begin
        sel_mag  = edge_mag[k];
        sel_sign = edge_sign[k];
      end
    end
  end

  assign out_msg  = {sel_sign, sel_mag};
  assign out_edge = ecnt_q;
  assign out_last = out_valid && (ecnt_q == LAST_EDGE);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ecnt_d   = ecnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (pop)       ecnt_d = 3'd0;
    else if (beat) ecnt_d = ecnt_q + 3'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ecnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ecnt_q   <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Directed bench for cnu_msg_gen: stimulus pushes hand-computed beats into a
// scoreboard queue, and a negedge monitor pops and compares each accepted beat.
module tb_cnu_msg_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_min = '0;
  logic [8:0] in_min2 = '0;
  logic [6:0] in_min_idx = '0;
  logic [6:0] in_signs = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_msg;
  logic [2:0] out_edge;
  logic       out_last;

  typedef struct packed {
    logic [9:0] msg;
    logic [2:0] edg;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int run_len = 0;
  int last_run = 0;

  cnu_msg_gen #(.data_w(9), .D(7), .OFFSET(1), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_min(in_min), .in_min2(in_min2), .in_min_idx(in_min_idx), .in_signs(in_signs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_edge(out_edge), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one compare set per accepted beat.
  always @(negedge clk) begin
    if (out_valid) run_len++;
    else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(out_edge), 32'd99);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        $display("beat edge=%0d msg=%03h last=%0d", out_edge, out_msg, out_last);
        chk("beat_edge", 32'(out_edge), 32'(e.edg));
        chk("beat_msg",  32'(out_msg),  32'(e.msg));
        chk("beat_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  // sg: expected sign per edge; edges in bm carry mag mb, others ma.
  task automatic push_exp(input logic [6:0] sg, input logic [8:0] ma, input logic [8:0] mb,
                          input logic [6:0] bm);
    for (int k = 0; k < 7; k++) begin
      beat_t e;
      e.msg  = {sg[k], (bm[k] ? mb : ma)};
      e.edg  = 3'(k);
      e.last = (k == 6);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [8:0] mn, input logic [8:0] mn2, input logic [6:0] idx,
                      input logic [6:0] sgn, output int acc_cyc);
    int n;
    in_valid = 1'b1;
    in_min = mn; in_min2 = mn2; in_min_idx = idx; in_signs = sgn;
    acc_cyc = -1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) chk("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    $display("record min=%0d min2=%0d idx=%b signs=%b accepted", mn, mn2, idx, sgn);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      if (!out_valid && exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_edge(input logic [2:0] target);
    int n;
    for (n = 0; n < 50; n++) begin
      if (out_valid && out_edge == target) break;
      @(posedge clk);
      #1;
    end
    chk("wait_edge_found", 32'(out_edge), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_edge", 32'(out_edge), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic expansion, also first-beat latency
    push_exp(7'b0000011, 9'd4, 9'd8, 7'b0000100);
    send(9'd5, 9'd9, 7'b0000100, 7'b0000011, a0);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_edge", 32'(out_edge), 32'd0);
    wait_idle();

    // Saturation at zero
    push_exp(7'b0111111, 9'd0, 9'd0, 7'b0000001);
    send(9'd0, 9'd1, 7'b0000001, 7'b1000000, a0);
    wait_idle();

    // Backpressure on edge 3
    push_exp(7'b1010101, 9'd19, 9'd29, 7'b0001000);
    send(9'd20, 9'd30, 7'b0001000, 7'b0101010, a0);
    wait_edge(3'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_edge", 32'(out_edge), 32'd3);
      chk("stall_msg", 32'(out_msg), 32'h01D);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("after_stall_edge", 32'(out_edge), 32'd4);
    wait_idle();

    // Fill and back-to-back: three records
    push_exp(7'b0000000, 9'd9, 9'd11, 7'b1000000);
    push_exp(7'b0000000, 9'd2, 9'd99, 7'b0000001);
    push_exp(7'b1111110, 9'd0, 9'd1, 7'b0010010);
    send(9'd10, 9'd12, 7'b1000000, 7'b0000000, a0);
    send(9'd3, 9'd100, 7'b0000001, 7'b1111111, a1);
    chk("b2b_consecutive", 32'(a1 - a0), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    send(9'd1, 9'd2, 7'b0010010, 7'b0000001, a2);
    chk("third_accept_delay", 32'(a2 - a1), 32'd7);
    wait_idle();
    @(posedge clk);
    #1 chk("valid_run_len", 32'(last_run), 32'd21);

    // Reset mid-record with a second record buffered
    push_exp(7'b0000011, 9'd4, 9'd8, 7'b0000100);
    push_exp(7'b0111111, 9'd0, 9'd0, 7'b0000001);
    send(9'd5, 9'd9, 7'b0000100, 7'b0000011, a0);
    send(9'd0, 9'd1, 7'b0000001, 7'b1000000, a1);
    wait_edge(3'd4);
    rst = 1'b1;
    exp_q.delete();
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_edge", 32'(out_edge), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 chk("mid_rst_still_empty", 32'(out_valid), 32'd0);

    // Zero min_idx after reset: min2 never used
    push_exp(7'b0000000, 9'd6, 9'd0, 7'b0000000);
    send(9'd7, 9'd3, 7'b0000000, 7'b0000000, a0);
    chk("zero_idx_first_edge", 32'(out_edge), 32'd0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
